cmp_seq_ctrl: RTL

//  Sequencer for the pipelined magnitude comparator. Compares two multi-word

---
 rtl/cmp_seq_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl
// Sequencer for a pipelined multi-word magnitude comparator. Issues word
// indices most-significant first, tags each issue so that only genuine
// comparator results are consumed, and folds the returned GR/EQ pairs into a
// single result. It stops at the first unequal word.
module cmp_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4,
    parameter int LAT   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_nwords,
    output logic          o_rd_en,
    output logic [CW-1:0] o_rd_idx,
    output logic          o_cmp_en,
    input  logic          i_cmp_gr,
    input  logic          i_cmp_eq,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_gr,
    output logic          o_eq
);

    // WIDTH only describes the operand slices; LAT must be at least one stage
    if (WIDTH < 1 || LAT < 1) begin : g_param_check
        $error("cmp_seq_ctrl: WIDTH and LAT must both be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_rd_en;
    logic [CW-1:0]   r_rd_idx;
    logic            r_cmp_en;
    logic            r_busy;
    logic            r_done;
    logic            r_gr;
    logic            r_eq;
    logic [LAT-1:0]  r_tag;

    logic [CW-1:0]   w_idx_nxt;
    logic            w_gr_nxt;
    logic            w_eq_nxt;
    logic            w_busy_nxt;
    logic            w_hit;
    logic            w_mismatch;
    logic [LAT-1:0]  w_rest;
    logic [LAT-1:0]  w_tag_shift;

    assign o_rd_en  = r_rd_en;
    assign o_rd_idx = r_rd_idx;
    assign o_cmp_en = r_cmp_en;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_gr     = r_gr;
    assign o_eq     = r_eq;

    // Bit LAT-1 of the tag marks that the comparator output belongs to a real
    // issue; the remaining bits tell whether any other result is still in flight
    always_comb begin
        w_hit         = r_tag[LAT-1];
        w_mismatch    = w_hit && !i_cmp_eq;
        w_rest        = r_tag;
        w_rest[LAT-1] = 1'b0;
        w_tag_shift    = r_tag << 1;
        w_tag_shift[0] = r_rd_en;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next index and result folding
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_rd_idx;
        w_gr_nxt    = r_gr;
        w_eq_nxt    = r_eq;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_gr_nxt = 1'b0;
                    if (i_nwords == '0) begin
                        w_state_nxt = ST_DONE;
                        w_eq_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_eq_nxt    = 1'b0;
                        w_idx_nxt   = i_nwords - CW'(1);
                    end
                end
            end
            ST_ISSUE: begin
                if (w_mismatch) begin
                    w_state_nxt = ST_DONE;
                    w_gr_nxt    = i_cmp_gr;
                    w_eq_nxt    = 1'b0;
                end else if (r_rd_idx == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_idx_nxt = r_rd_idx - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (w_mismatch) begin
                    w_state_nxt = ST_DONE;
                    w_gr_nxt    = i_cmp_gr;
                    w_eq_nxt    = 1'b0;
                end else if ((w_hit && w_rest == '0) || r_tag == '0) begin
                    w_state_nxt = ST_DONE;
                    w_gr_nxt    = 1'b0;
                    w_eq_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
    end

    // Registered outputs and the in-flight tag line; tags are flushed whenever
    // the compare ends so stale results can never leak into the next one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_en  <= 1'b0;
            r_rd_idx <= '0;
            r_cmp_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_gr     <= 1'b0;
            r_eq     <= 1'b0;
            r_tag    <= '0;
        end else begin
            r_rd_en  <= (w_state_nxt == ST_ISSUE);
            r_rd_idx <= w_idx_nxt;
            r_cmp_en <= w_busy_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= (w_state_nxt == ST_DONE);
            r_gr     <= w_gr_nxt;
            r_eq     <= w_eq_nxt;
            if (!w_busy_nxt) begin
                r_tag <= '0;
            end else if (r_cmp_en) begin
                r_tag <= w_tag_shift;
            end
        end
    end

endmodule
